// File: rtl/regbank_dump_rd_pkg.sv
// regbank_dump_rd_pkg: FSM encoding and default sizes shared by the dump register bank and its storage
package regbank_dump_rd_pkg;
    localparam int NREGS = 8;
    localparam int WIDTH = 32;
    localparam int AW = $clog2(NREGS);
    localparam int LAST_IDX = NREGS - 1;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/regbank_dump_rd_store.sv
// regbank_dump_rd_store: NREGS x WIDTH storage; ports clk/r, write (wr_en/wr_addr/wr_data), random read (rd_addr->rd_data), dump read (dump_addr->dump_data)
module regbank_dump_rd_store
    import regbank_dump_rd_pkg::*;
#(
    parameter int N = NREGS,
    parameter int W = WIDTH,
    parameter int A = AW
) (
    input  logic         clk,
    input  logic         r,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [A-1:0] rd_addr,
    output logic [W-1:0] rd_data,
    input  logic [A-1:0] dump_addr,
    output logic [W-1:0] dump_data
);
    logic [W-1:0] mem [N];
    for (genvar g = 0; g < N; g++) begin : g_ent
        always_ff @(posedge clk)
            if (r) mem[g] <= '0;
            else if (wr_en && wr_addr == A'(g)) mem[g] <= wr_data;
    end
    assign rd_data = mem[rd_addr];
    assign dump_data = mem[dump_addr];
endmodule

// File: rtl/regbank_dump_rd.sv
// regbank_dump_rd: register bank with random read and a valid/ready dump streamer; ports clk/r, write, rd_addr->rd_data, dump_start/dump_busy, out_valid/out_ready/out_data/out_idx/out_last
module regbank_dump_rd
    import regbank_dump_rd_pkg::*;
#(
    parameter int NREGS = regbank_dump_rd_pkg::NREGS,
    parameter int WIDTH = regbank_dump_rd_pkg::WIDTH,
    parameter int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_idx,
    output logic             out_last
);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    state_t state, next;
    logic load, at_last;
    logic [AW-1:0] ld_idx;
    logic [WIDTH-1:0] dump_data, ld_data;
    regbank_dump_rd_store #(.N(NREGS), .W(WIDTH), .A(AW)) u_store (
        .clk(clk), .r(r), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .dump_addr(ld_idx), .dump_data(dump_data)
    );
    assign at_last = out_idx == LAST;
    always_comb begin
        next = state;
        load = 1'b0;
        ld_idx = state == IDLE ? '0 : out_idx + AW'(1);
        if (state == IDLE) begin
            next = dump_start ? SEND : IDLE;
            load = dump_start;
        end else if (out_ready) begin
            next = at_last ? IDLE : SEND;
            load = !at_last;
        end
    end
    // the word being written on the load edge is newer than the stored one
    assign ld_data = (wr_en && wr_addr == ld_idx) ? wr_data : dump_data;
    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
            out_idx <= '0;
            out_data <= '0;
        end else begin
            state <= next;
            if (load) begin
                out_idx <= ld_idx;
                out_data <= ld_data;
            end
        end
    end
    assign out_valid = state == SEND;
    assign dump_busy = state == SEND;
    assign out_last = out_valid && at_last;
endmodule

// File: tb/tb_regbank_dump_rd.sv
// tb_regbank_dump_rd: directed scoreboard bench for regbank_dump_rd
module tb_regbank_dump_rd;
    import regbank_dump_rd_pkg::*;
    typedef struct {logic [AW-1:0] idx; logic [WIDTH-1:0] data;} beat_t;
    logic clk = 1'b0;
    logic r, wr_en, dump_start, dump_busy, out_valid, out_ready, out_last;
    logic [AW-1:0] wr_addr, rd_addr, out_idx;
    logic [WIDTH-1:0] wr_data, rd_data, out_data;
    beat_t sb[$];
    int checks = 0;
    int fails = 0;
    regbank_dump_rd dut (
        .clk(clk), .r(r), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .dump_start(dump_start), .dump_busy(dump_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic push(input int i, input logic [WIDTH-1:0] d);
        beat_t b;
        b.idx = AW'(i);
        b.data = d;
        sb.push_back(b);
    endtask
    task automatic step();
        beat_t b;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("extra_beat", 32'(out_idx), 32'hFFFF_FFFF);
            else begin
                b = sb.pop_front();
                chk("beat_idx", 32'(out_idx), 32'(b.idx));
                chk("beat_data", out_data, b.data);
                chk("beat_last", 32'(out_last), 32'(b.idx == AW'(LAST_IDX)));
                chk("beat_busy", 32'(dump_busy), 32'd1);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        r = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        dump_start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(); step();
        r = 1'b0; rd_addr = 3'd5; #1;
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_data", out_data, 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'hA000_0000 + 32'(i);
            step();
        end
        wr_en = 1'b0; rd_addr = 3'd3; #1;
        chk("rd_after_wr", rd_data, 32'hA000_0003);
        for (int i = 0; i < NREGS; i++) push(i, 32'hA000_0000 + 32'(i));
        dump_start = 1'b1; out_ready = 1'b1;
        step();
        dump_start = 1'b0;
        chk("busy_after_start", 32'(dump_busy), 32'd1);
        repeat (NREGS) step();
        chk("d1_valid_end", 32'(out_valid), 32'd0);
        chk("d1_busy_end", 32'(dump_busy), 32'd0);
        chk("d1_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < NREGS; i++)
            push(i, i == 4 ? 32'h1234_5678 : 32'hA000_0000 + 32'(i));
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        step(); step();
        out_ready = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        step(); step();
        chk("stall_idx", 32'(out_idx), 32'd2);
        chk("stall_data", out_data, 32'hA000_0002);
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("resume_idx", 32'(out_idx), 32'd3);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h1234_5678;
        step();
        wr_en = 1'b0;
        step();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        step();
        chk("pre_final_idx", 32'(out_idx), 32'd7);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("d2_valid_end", 32'(out_valid), 32'd0);
        chk("d2_sb_empty", 32'(sb.size()), 32'd0);
        step();
        chk("no_second_dump", 32'(out_valid), 32'd0);
        chk("hold_last_idx", 32'(out_idx), 32'd7);
        rd_addr = 3'd2; #1;
        chk("rd_entry2", rd_data, 32'hDEAD_BEEF);
        push(0, 32'hA000_0000); push(1, 32'hA000_0001);
        push(2, 32'hDEAD_BEEF); push(3, 32'hA000_0003);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        repeat (4) step();
        chk("d3_idx4", 32'(out_idx), 32'd4);
        out_ready = 1'b0; r = 1'b1;
        step();
        r = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(dump_busy), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("d3_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = AW'(i); #1;
            chk("mid_rst_entry", rd_data, 32'd0);
        end
        for (int i = 0; i < NREGS; i++) push(i, 32'd0);
        out_ready = 1'b1; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        repeat (NREGS) step();
        chk("d4_valid_end", 32'(out_valid), 32'd0);
        chk("d4_sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/regbank_dump_rd.md
Name: regbank_dump_rd

Overview:
- 8 x 32-bit register bank with one write port and one combinational read port.
- Includes a dump sequencer that reads every entry in order and streams it out over a valid/ready interface.
- Used for architectural-state dump and debug readout.
- It is the read-side counterpart to the enable-gated flop banks: it consumes stored words rather than capturing them.

Parameters:
- NREGS, 8, number of entries; must be a power of two, at least 2.
- WIDTH, 32, data width per entry.
- AW, 3, address width, equal to log2(NREGS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- r  in  1  reset, synchronous, active-high.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write index.
- wr_data  in  WIDTH  write data.
- rd_addr  in  AW  random-read index.
- rd_data  out  WIDTH  combinational value of entry rd_addr; no write bypass.
- dump_start  in  1  one-cycle request to begin a dump.
- dump_busy  out  1  high from the cycle after an accepted start until the last beat is accepted.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  beat data; registered.
- out_idx  out  AW  entry index of the current beat.
- out_last  out  1  high when out_idx == NREGS-1 and out_valid is high.

Behaviour:
- Reset (r=1 at an edge):
  - All entries become 0.
  - FSM goes to IDLE.
  - out_valid, dump_busy, out_last, out_idx and out_data all become 0.
  - Reset overrides wr_en and dump_start in the same cycle.
  - Reset mid-dump aborts the dump: out_valid is 0 from the next cycle; no further beats.
- Write: when wr_en=1 at an edge, entry[wr_addr] <= wr_data. Writes are allowed in every FSM state.
- FSM states: IDLE, SEND.
- IDLE:
  - dump_start=1 moves to SEND.
  - On that edge: out_idx <= 0, out_data <= entry[0], out_valid <= 1, dump_busy <= 1.
  - Latency: start at edge N gives a valid beat in cycle N+1.
- SEND:
  - Transfer occurs when out_valid && out_ready at an edge.
  - Transfer with out_idx != NREGS-1: out_idx <= out_idx+1, out_data <= entry[out_idx+1]. out_valid stays 1, so throughput is one beat per cycle.
  - Transfer with out_idx == NREGS-1: move to IDLE; out_valid and dump_busy go to 0 next cycle. out_idx and out_data hold their last values.
  - No transfer: out_idx and out_data hold. They are stable while stalled even if the entry is rewritten.
- Write bypass on load: when out_data is loaded from entry[k] on an edge where wr_en=1 and wr_addr==k, it loads wr_data instead.
  - This applies to both the IDLE->SEND load (k=0) and the advance load (k=out_idx+1).
  - Consequence: every beat reflects all writes up to and including the load edge.
- Writes to an index already sent, or to the beat currently held, do not affect the stream.
- dump_start while in SEND is ignored; no queueing.
- A new dump_start on the same edge as the final transfer is also ignored. The FSM must be in IDLE when dump_start is sampled.
- out_ready is don't-care while out_valid=0.
- Index wrap: out_idx never wraps within a dump. The last-beat check uses equality with NREGS-1, not counter overflow.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, SEND=1).
  - Default NREGS, WIDTH and AW constants.
  - Derived localparam LAST_IDX = NREGS-1.
- Sub-module regbank_store: NREGS x WIDTH storage with per-entry write enable decoded from wr_addr, one combinational read port for rd_data, and a second read port for the dump load mux.
- The top level holds the FSM, the index counter, the output register and the bypass compare.

Test Plan:
- Reset then idle read:
  - Stimulus: r=1 for 2 cycles, then rd_addr=5.
  - Required: rd_data=0; out_valid=0; dump_busy=0.
- Back-to-back dump:
  - Stimulus: write entry[i]=0xA000_0000+i for i=0..7; pulse dump_start; hold out_ready=1.
  - Required: 8 consecutive beats with out_data=0xA000_0000..0xA000_0007 and out_idx=0..7.
  - Required: out_last only on beat 7; dump_busy=0 the cycle after.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles at idx 2, and write entry[2]=0xDEAD_BEEF during the stall.
  - Required: out_data holds at 0xA000_0002 and idx holds at 2; the dump then resumes with idx 3.
- Bypass:
  - Stimulus: at idx 3 with out_ready=1, write entry[4]=0x1234_5678 on the same edge.
  - Required: beat 4 carries 0x1234_5678.
- Ignored start:
  - Stimulus: pulse dump_start at idx 5, and again on the final-transfer edge.
  - Required: the sequence is unchanged; no second dump (out_valid=0 after beat 7).
- Reset mid-dump:
  - Stimulus: assert r at idx 4.
  - Required: out_valid=0 next cycle; all entries read 0; a new dump returns all zeros.
